// File: rtl/stage_tl_pkg.sv
// Shared types for the translate/branch-resolve stage (stage_tl).
//   extl_t       : record arriving from the execute stage
//   tlc_t        : registered record sent to the cache stage
//   dtlb_entry_t : one fully associative DTLB entry
// The ppn field of a DTLB entry is sized for the widest legal PPN. Narrower
// configurations store their PPN zero-extended.
package stage_tl_pkg;

    localparam int unsigned PAGE_OFFSET_W = 12;
    localparam int unsigned VPN_W         = 20;
    localparam int unsigned PPN_MAX_W     = 20;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] mul;
        logic        is_equal;
        logic [31:0] r2;
        logic [31:0] pc;
        logic [4:0]  dst;
        logic [1:0]  thread;
        logic        is_valid;
        logic        itlb_miss;
        logic        flag_mem;
        logic        flag_store;
        logic        flag_isbyte;
        logic        flag_mul;
        logic        flag_reg;
        logic        flag_iret;
        logic        flag_branch;
        logic        flag_jump;
        logic        flag_tlbwrite;
    } extl_t;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] mul;
        logic [31:0] r2;
        logic [31:0] pc;
        logic [4:0]  dst;
        logic [1:0]  thread;
        logic        is_valid;
        logic        itlb_miss;
        logic        flag_mem;
        logic        flag_store;
        logic        flag_isbyte;
        logic        flag_mul;
        logic        flag_reg;
        logic        flag_iret;
        logic [31:0] addr;
        logic        dtlb_miss;
        logic        priv_fault;
    } tlc_t;

    typedef struct packed {
        logic                 valid;
        logic [VPN_W-1:0]     vpn;
        logic [PPN_MAX_W-1:0] ppn;
    } dtlb_entry_t;

    function automatic logic [VPN_W-1:0] vpn_of(input logic [31:0] va);
        return va[31:PAGE_OFFSET_W];
    endfunction

endpackage

// File: rtl/stage_tl_dtlb.sv
// Fully associative data TLB with FIFO replacement.
//   clk, rst            : clock, asynchronous active-low reset
//   lookup_vpn -> hit,ppn : combinational lookup, lowest matching index wins
//   write_en/vpn/ppn    : install a translation; an existing entry for the
//                         same vpn is overwritten in place without moving the
//                         replacement pointer
module dtlb
    import stage_tl_pkg::*;
#(
    parameter int unsigned ENTRIES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [VPN_W-1:0]     lookup_vpn,
    output logic                 hit,
    output logic [PPN_MAX_W-1:0] ppn,
    input  logic                 write_en,
    input  logic [VPN_W-1:0]     write_vpn,
    input  logic [PPN_MAX_W-1:0] write_ppn
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);

    dtlb_entry_t       entries [ENTRIES];
    logic [IDX_W-1:0]  ptr;
    logic              wr_hit;
    logic [IDX_W-1:0]  wr_idx;

    always_comb begin
        hit    = 1'b0;
        ppn    = '0;
        wr_hit = 1'b0;
        wr_idx = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (!hit && entries[i].valid && entries[i].vpn == lookup_vpn) begin
                hit = 1'b1;
                ppn = entries[i].ppn;
            end
            if (!wr_hit && entries[i].valid && entries[i].vpn == write_vpn) begin
                wr_hit = 1'b1;
                wr_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                entries[i] <= '0;
            end
            ptr <= '0;
        end else if (write_en) begin
            if (wr_hit) begin
                entries[wr_idx] <= '{valid: 1'b1, vpn: write_vpn, ppn: write_ppn};
            end else begin
                entries[ptr] <= '{valid: 1'b1, vpn: write_vpn, ppn: write_ppn};
                ptr          <= (ptr == IDX_W'(ENTRIES - 1)) ? '0 : ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stage_tl.sv
// Translate stage: resolves branches/jumps, translates data addresses
// through the DTLB, performs tlbwrite, and registers a TLC record.
//   clk, rst     : clock, asynchronous active-low reset
//   in           : EXTL record from execute
//   supervisor   : privilege of `in` (1 = bypass translation, may tlbwrite)
//   stall_in     : cache stage cannot accept; all state holds
//   stall_out    : stall request to upstream (= stall_in)
//   out          : registered TLC record
//   redirect/_pc : registered taken branch/jump and its target
module stage_tl
    import stage_tl_pkg::*;
#(
    parameter int unsigned DTLB_ENTRIES = 4,
    parameter int unsigned PPN_W        = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  extl_t       in,
    input  logic        supervisor,
    input  logic        stall_in,
    output logic        stall_out,
    output tlc_t        out,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    // Physical address is PPN_W+12 bits, zero-extended to 32.
    localparam logic [31:0] PA_MASK = 32'((64'd1 << (PPN_W + PAGE_OFFSET_W)) - 64'd1);

    logic                 eff;
    logic                 taken;
    logic                 xlate;
    logic                 tlb_wr;
    logic                 fault;
    logic                 miss;
    logic                 hit;
    logic [PPN_MAX_W-1:0] hit_ppn;
    tlc_t                 nxt;

    assign stall_out = stall_in;
    assign eff       = in.is_valid & ~in.itlb_miss;
    assign taken     = eff & (in.flag_jump | (in.flag_branch & in.is_equal));
    assign xlate     = eff & in.flag_mem;
    assign tlb_wr    = eff & in.flag_tlbwrite & supervisor & ~stall_in;
    assign fault     = eff & in.flag_tlbwrite & ~supervisor;
    assign miss      = xlate & ~supervisor & ~hit;

    dtlb #(.ENTRIES(DTLB_ENTRIES)) u_dtlb (
        .clk        (clk),
        .rst        (rst),
        .lookup_vpn (vpn_of(in.data)),
        .hit        (hit),
        .ppn        (hit_ppn),
        .write_en   (tlb_wr),
        .write_vpn  (vpn_of(in.data)),
        .write_ppn  (PPN_MAX_W'(in.r2[PPN_W-1:0]))
    );

    always_comb begin
        nxt             = '0;
        nxt.data        = in.data;
        nxt.mul         = in.mul;
        nxt.r2          = in.r2;
        nxt.pc          = in.pc;
        nxt.dst         = in.dst;
        nxt.thread      = in.thread;
        nxt.is_valid    = in.is_valid;
        nxt.itlb_miss   = in.itlb_miss;
        // A DTLB miss travels to commit as an exception; the cache must ignore it.
        nxt.flag_mem    = in.flag_mem & ~miss;
        nxt.flag_store  = in.flag_store;
        nxt.flag_isbyte = in.flag_isbyte;
        nxt.flag_mul    = in.flag_mul;
        nxt.flag_reg    = in.flag_reg;
        nxt.flag_iret   = in.flag_iret;
        nxt.dtlb_miss   = miss;
        nxt.priv_fault  = fault;
        if (xlate) begin
            if (supervisor) begin
                nxt.addr = in.data & PA_MASK;
            end else if (hit) begin
                nxt.addr = {hit_ppn, in.data[PAGE_OFFSET_W-1:0]} & PA_MASK;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out         <= '0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
        end else if (!stall_in) begin
            out         <= nxt;
            redirect    <= taken;
            redirect_pc <= in.data;
        end
    end

endmodule

// File: doc/stage_tl.md
Name: stage_tl

Overview:
Pipeline stage directly downstream of the execute stage. It consumes the EXTL record, resolves branches and jumps, and translates data addresses through a small fully associative DTLB. It also performs DTLB writes for tlbwrite instructions and emits a registered TLC record to the cache stage. It honours a backpressure stall from the cache stage.

Parameters:
- DTLB_ENTRIES, 4, number of fully associative DTLB entries (power of two, 2..16).
- PPN_W, 8, physical page number width. Physical address = {ppn, va[11:0]}, i.e. 20 bits at default.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in  in  EXTL  record from the execute stage (data, mul, is_equal, r2, pc, dst, thread, is_valid, itlb_miss, flags).
- supervisor  in  1  privilege of the instruction in `in`. 1 = supervisor: translation bypassed, tlbwrite allowed.
- stall_in  in  1  cache stage cannot accept a new record.
- stall_out  out  1  asks upstream to hold `in`. Equals stall_in, combinational.
- out  out  TLC  registered record to the cache stage.
- redirect  out  1  registered. Taken branch or jump resolved this cycle.
- redirect_pc  out  32  registered target. Valid when redirect=1.

Behaviour:
- Reset (rst=0, asynchronous):
  - all DTLB valid bits cleared; replacement pointer = 0;
  - out cleared (is_valid=0, all flags 0, data/addr 0);
  - redirect=0, redirect_pc=0.
- Latency: one cycle, in -> out and redirect.
- Stall: while stall_in=1, out/redirect/redirect_pc hold their values and no DTLB write occurs. The upstream stage holds `in`, so the instruction is re-evaluated when stall_in drops.
- Effective instruction: eff = in.is_valid & ~in.itlb_miss. When eff=0:
  - no TLB write, no redirect, no dtlb_miss;
  - out.is_valid is copied from in; other bypass fields are copied as-is.
- Branch resolution: taken = eff & (in.flag_jump | (in.flag_branch & in.is_equal)).
  - Registered: redirect <= taken; redirect_pc <= in.data (execute computes the target as the ALU result).
  - redirect deasserts the next cycle unless another taken instruction arrives.
- Translation applies when eff & in.flag_mem.
  - va = in.data. vpn = va[31:12].
  - supervisor=1: pa = va[PPN_W+11:0], no lookup.
  - supervisor=0: compare vpn against all valid entries.
    - Hit: pa = {ppn, va[11:0]}. On multiple hits the lowest index wins.
    - Miss: out.dtlb_miss=1, out.is_valid=1 (exception carried to commit), out.flag_mem forced 0 so the cache ignores it.
- DTLB write when eff & in.flag_tlbwrite & supervisor & ~stall_in:
  - entry[ptr] <= {valid=1, vpn=in.data[31:12], ppn=in.r2[PPN_W-1:0]};
  - ptr <= ptr+1, wrapping DTLB_ENTRIES-1 -> 0 (FIFO replacement).
  - If the vpn is already present, that entry is overwritten instead and ptr does not advance.
  - The written translation is visible to the next instruction (no bypass needed within the same cycle, since one instruction per cycle).
- tlbwrite with supervisor=0: no write; out.priv_fault=1.
- out fields (when not stalled):
  - addr <= pa zero-extended;
  - data/mul/r2/dst/pc/thread/flag_store/flag_isbyte/flag_mul/flag_reg/flag_iret <= in;
  - dtlb_miss and priv_fault as above, otherwise 0.
- Reset during a stall: reset wins; all state cleared immediately.

Decomposition:
- Shared package (common):
  - TLC struct (EXTL fields minus is_equal/flag_branch/flag_jump/flag_tlbwrite, plus addr, dtlb_miss, priv_fault);
  - dtlb_entry_t {valid, vpn[19:0], ppn};
  - constants PAGE_OFFSET_W=12, VPN_W=20.
- Sub-module `dtlb`: entry array, FIFO pointer, parallel compare plus priority encoder.
  - Ports: clk, rst, lookup vpn -> hit/ppn, write enable/vpn/ppn.
- stage_tl instantiates dtlb and holds the pipeline register and branch logic.

Test Plan:
- Reset: hold rst=0 mid-stream with stall_in=1 -> out.is_valid=0, redirect=0, all DTLB entries invalid; after release a user load to va 0x00003010 -> dtlb_miss=1, flag_mem=0.
- TLB fill/hit:
  - supervisor tlbwrite data=0x00003000, r2=0x5A, then user load va 0x00003010 -> out.addr=0x5A010, dtlb_miss=0.
  - Supervisor load va 0x00003010 -> addr=0x03010.
- FIFO wrap: 5 tlbwrites, vpns 1..5, DTLB_ENTRIES=4 -> vpn 1 evicted (miss), vpns 2..5 hit. Rewriting vpn 3 with ppn 0x77 -> no pointer advance, vpn 3 maps to 0x77.
- Branch: flag_branch=1, is_equal=1, data=0x1000 -> next cycle redirect=1, redirect_pc=0x1000. Same with is_equal=0 -> redirect=0. Jump with is_valid=0 -> redirect=0.
- Stall: assert stall_in for 3 cycles while a tlbwrite is presented -> out unchanged and no write until stall_in falls, then exactly one write (ptr +1).
- Faults: user tlbwrite -> priv_fault=1, no entry written. itlb_miss=1 with flag_mem=1 -> no lookup, dtlb_miss=0, itlb_miss propagated.
